// File: rtl/m31_mod_reduce_pipe_pkg.sv
// Shared M31 (p = 2^31-1) definitions for the modular-reduction pipeline.
// Provides the field width and modulus, the element type, and the single
// fold step x -> x[30:0] + (x >> 31) used by both pipeline stages.
package m31_pkg;

  localparam int              M31_W = 31;
  localparam logic [M31_W-1:0] M31_P = 31'h7FFF_FFFF;

  typedef logic [M31_W-1:0] m31_t;

  // One fold: since 2^31 == 1 (mod p), the high part can be added onto the
  // low 31 bits without changing the residue. The result fits in 32 bits for
  // any x < 2^62, which covers every legal input width.
  function automatic logic [31:0] m31_fold(input logic [63:0] x);
    return 32'(x[30:0]) + 32'(x >> 31);
  endfunction

endpackage

// File: rtl/m31_mod_reduce_pipe_if.sv
// Stream interface of the M31 reducer: one valid/ready beat per cycle in each
// direction. Each beat carries LANES words plus a sideband tag.
//   in_valid/in_ready/in_data/in_tag     : upstream beat (LANES*DATA_WIDTH data)
//   out_valid/out_ready/out_data/out_tag : downstream beat (LANES*31 data)
// Modports: master = the producer/consumer environment, slave = the reducer.
interface m31_mod_reduce_pipe_if
  import m31_pkg::*;
#(
  parameter int DATA_WIDTH = 62,
  parameter int LANES      = 1,
  parameter int TAG_WIDTH  = 1
);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0]        in_tag;

  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*M31_W-1:0]      out_data;
  logic [TAG_WIDTH-1:0]        out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/m31_mod_reduce_pipe_fold_lane.sv
// m31_fold_lane: combinational single-lane M31 fold.
//   x_i : unreduced word, IN_W bits (IN_W <= 62)
//   y_o : x_i[30:0] + (x_i >> 31), truncated to OUT_W bits
// OUT_W = 32 for the first stage; OUT_W = 31 for the second stage, where the
// input is already below 2^32-1 and the sum can never exceed p.
module m31_fold_lane
  import m31_pkg::*;
#(
  parameter int IN_W  = 62,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  x_i,
  output logic [OUT_W-1:0] y_o
);

  assign y_o = OUT_W'(m31_fold(64'(x_i)));

endmodule

// File: rtl/m31_mod_reduce_pipe.sv
// m31_mod_reduce_pipe: two-stage elastic pipeline reducing LANES unreduced
// words per beat modulo p = 2^31-1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (release expected synchronous)
//   bus   : slave side of m31_mod_reduce_pipe_if (in_* beat in, out_* beat out)
// S1 registers x[30:0] + (x >> 31) (<= 2^32-2); S2 registers a second fold,
// giving a value in [0, p]. Latency 2, throughput 1 beat/cycle; in_ready is
// combinational from the stage occupancy (no skid buffer).
// Build option: define M31_CANONICAL_EN to map p -> 0 in S2, making the
// output canonical in [0, p-1] at the same latency.
module m31_mod_reduce_pipe
  import m31_pkg::*;
#(
  parameter int DATA_WIDTH = 62,
  parameter int LANES      = 1,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  m31_mod_reduce_pipe_if.slave bus
);

  if (DATA_WIDTH < 32 || DATA_WIDTH > 62) begin : g_bad_width
    $error("m31_mod_reduce_pipe: DATA_WIDTH must be in 32..62");
  end

  logic                         s1_valid_q, s1_valid_d;
  logic                         s2_valid_q, s2_valid_d;
  logic                         s1_en, s2_en, in_fire;
  logic [LANES-1:0][31:0]       s1_fold, s1_data_q;
  logic [LANES-1:0][M31_W-1:0]  s2_fold, s2_data_d, s2_data_q;
  logic [TAG_WIDTH-1:0]         s1_tag_q, s2_tag_q;

  // A stage may load when its register is empty or is being emptied this cycle.
  assign s2_en   = !s2_valid_q || bus.out_ready;
  assign s1_en   = !s1_valid_q || s2_en;
  assign in_fire = bus.in_valid && s1_en;

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_tag   = s2_tag_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    m31_fold_lane #(.IN_W(DATA_WIDTH), .OUT_W(32)) u_s1_fold (
      .x_i (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .y_o (s1_fold[i])
    );

    m31_fold_lane #(.IN_W(32), .OUT_W(M31_W)) u_s2_fold (
      .x_i (s1_data_q[i]),
      .y_o (s2_fold[i])
    );

`ifdef M31_CANONICAL_EN
    // p is the only non-canonical value the second fold can produce.
    assign s2_data_d[i] = (s2_fold[i] == M31_P) ? '0 : s2_fold[i];
`else
    assign s2_data_d[i] = s2_fold[i];
`endif
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_en) s1_valid_d = bus.in_valid;
    if (s2_en) s2_valid_d = s1_valid_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      // NOTE: data/tag registers are reset too, because out_data/out_tag must read 0 after reset.
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      // Payload only moves with a real beat, so idle in_data never disturbs the pipe.
      if (in_fire) begin
        s1_data_q <= s1_fold;
        s1_tag_q  <= bus.in_tag;
      end
      if (s2_en && s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

endmodule
